demux1_4_reg: RTL and testbench

Registered 1-to-4 demultiplexer: the other end of the 4:1 select path. It takes one input stream plus a 2-bit select and steers each accepted word into one of four independent output channels. Each channel has a valid/ready handshake and a one-entry holding slot. It sits in the datapath wherever a single producer feeds four consumers that can stall independently, for example a write-back value fanned out to four destinations.

---
 rtl/demux_pkg.sv | 33 +++
 rtl/demux_slot.sv | 55 +++++
 rtl/demux1_4_reg.sv | 82 ++++++++
 tb/tb_demux1_4_reg.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants for the registered 1-to-4 demultiplexer.
// Holds select codes, channel indices, default widths and the select decoder.
package demux_pkg;

    localparam int DEF_W     = 16;
    localparam int DEF_CNT_W = 8;
    localparam int NUM_CH    = 4;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    localparam int CH_A = 0;
    localparam int CH_B = 1;
    localparam int CH_C = 2;
    localparam int CH_D = 3;

    function automatic logic [NUM_CH-1:0] selToOneHot(
        input logic [1:0] sel
    );
        logic [NUM_CH-1:0] oh;
        oh = '0;
        unique case (sel)
            SEL_A: oh[CH_A] = 1'b1;
            SEL_B: oh[CH_B] = 1'b1;
            SEL_C: oh[CH_C] = 1'b1;
            SEL_D: oh[CH_D] = 1'b1;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel of demux1_4_reg: a one-entry holding slot.
// Ports: clk, rst (async, active-high), load/loadData from the
// select decode, outReady from the consumer; exports valid, data
// and canLoad (slot empty or draining this cycle). With
// DEMUX1_4_REG_CNT_EN defined, cnt counts delivered words.
module demux_slot
    import demux_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] loadData,
    input  logic         outReady,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         canLoad
`ifdef DEMUX1_4_REG_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    logic drain;

    assign drain   = valid & outReady;
    assign canLoad = !valid | outReady;

    // Load wins over drain so a word can pipe through at full rate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= loadData;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

`ifdef DEMUX1_4_REG_CNT_EN
    // Counts drains only; wraps modulo 2**CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (drain) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/demux1_4_reg.sv
// Registered 1-to-4 demultiplexer with per-channel valid/ready slots.
// Ports: clk, rst (async, active-high); in_data/in_sel/in_valid/in_ready
// upstream; out_dataA..D, out_valid[3:0], out_ready[3:0] downstream.
// Optional DEMUX1_4_REG_CNT_EN adds cnt_A..cnt_D delivery counters.
module demux1_4_reg
    import demux_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_dataA,
    output logic [W-1:0] out_dataB,
    output logic [W-1:0] out_dataC,
    output logic [W-1:0] out_dataD,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready
`ifdef DEMUX1_4_REG_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_A,
    output logic [CNT_W-1:0] cnt_B,
    output logic [CNT_W-1:0] cnt_C,
    output logic [CNT_W-1:0] cnt_D
`endif
);

    logic [NUM_CH-1:0] selOneHot;
    logic [NUM_CH-1:0] canLoad;
    logic [NUM_CH-1:0] loadVec;
    logic [NUM_CH-1:0] slotValid;
    logic [W-1:0]      slotData [NUM_CH];
    logic              accept;
`ifdef DEMUX1_4_REG_CNT_EN
    logic [CNT_W-1:0]  slotCnt [NUM_CH];
`endif

    assign selOneHot = selToOneHot(in_sel);

    // Ready only depends on the addressed slot; held low in reset.
    assign in_ready = !rst && (|(selOneHot & canLoad));
    assign accept   = in_valid & in_ready;
    assign loadVec  = selOneHot & {NUM_CH{accept}};

    for (genvar i = 0; i < NUM_CH; i++) begin : gSlot
        demux_slot #(
            .W     (W),
            .CNT_W (CNT_W)
        ) uSlot (
            .clk      (clk),
            .rst      (rst),
            .load     (loadVec[i]),
            .loadData (in_data),
            .outReady (out_ready[i]),
            .valid    (slotValid[i]),
            .data     (slotData[i]),
            .canLoad  (canLoad[i])
`ifdef DEMUX1_4_REG_CNT_EN
            ,
            .cnt      (slotCnt[i])
`endif
        );
    end

    assign out_valid = slotValid;
    assign out_dataA = slotData[CH_A];
    assign out_dataB = slotData[CH_B];
    assign out_dataC = slotData[CH_C];
    assign out_dataD = slotData[CH_D];

`ifdef DEMUX1_4_REG_CNT_EN
    assign cnt_A = slotCnt[CH_A];
    assign cnt_B = slotCnt[CH_B];
    assign cnt_C = slotCnt[CH_C];
    assign cnt_D = slotCnt[CH_D];
`endif

endmodule

// File: tb/tb_demux1_4_reg.sv
// Directed, scoreboard-checked bench for demux1_4_reg.
// Expected words are queued per channel on accept and popped on drain.
`timescale 1ns/1ps
module tb_demux1_4_reg;

    localparam int W     = 16;
    localparam int CNT_W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] inData = '0;
    logic [1:0]   inSel = '0;
    logic         inValid = 1'b0;
    logic         inReady;
    logic [W-1:0] outDataA, outDataB, outDataC, outDataD;
    logic [3:0]   outValid;
    logic [3:0]   outReady = '0;
`ifdef DEMUX1_4_REG_CNT_EN
    logic [CNT_W-1:0] cntA, cntB, cntC, cntD;
`endif

    logic [W-1:0]     sbQ [4][$];
    logic [CNT_W-1:0] expCnt [4];
    int nCmp  = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    demux1_4_reg #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (inData),
        .in_sel    (inSel),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .out_dataA (outDataA),
        .out_dataB (outDataB),
        .out_dataC (outDataC),
        .out_dataD (outDataD),
        .out_valid (outValid),
        .out_ready (outReady)
`ifdef DEMUX1_4_REG_CNT_EN
        ,
        .cnt_A     (cntA),
        .cnt_B     (cntB),
        .cnt_C     (cntC),
        .cnt_D     (cntD)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] dataOf(input int i);
        case (i)
            0: return outDataA;
            1: return outDataB;
            2: return outDataC;
            default: return outDataD;
        endcase
    endfunction

    task automatic chkCnt(input string tag);
`ifdef DEMUX1_4_REG_CNT_EN
        chk({tag, "_cntA"}, cntA, expCnt[0]);
        chk({tag, "_cntB"}, cntB, expCnt[1]);
        chk({tag, "_cntC"}, cntC, expCnt[2]);
        chk({tag, "_cntD"}, cntD, expCnt[3]);
`else
        chk({tag, "_noCnt"}, {28'd0, outValid}, {28'd0, outValid} & 32'hF);
`endif
    endtask

    // Sample handshakes at negedge, update scoreboard, step one edge.
    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (outValid[i] && outReady[i]) begin
                expCnt[i]++;
                if (sbQ[i].size() > 0)
                    chk($sformatf("drain%0d", i), dataOf(i),
                        sbQ[i].pop_front());
                else
                    chk($sformatf("underflow%0d", i), outValid[i], 0);
            end
        end
        if (inValid && inReady)
            sbQ[inSel].push_back(inData);
        @(posedge clk);
        #1;
    endtask

    task automatic clearModel();
        for (int i = 0; i < 4; i++) begin
            sbQ[i].delete();
            expCnt[i] = '0;
        end
    endtask

    initial begin
        clearModel();

        // Reset asserted mid-cycle.
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", outValid, 4'b0000);
        chk("rst_ready", inReady, 0);
        chk("rst_dataA", outDataA, 0);
        chk("rst_dataC", outDataC, 0);
        chkCnt("rst");
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("post_rst_ready", inReady, 1);

        // Route 1234 to C.
        inData = 16'h1234; inSel = 2'b10; inValid = 1'b1;
        cycle();
        inValid = 1'b0;
        #1;
        chk("routeC_valid", outValid, 4'b0100);
        chk("routeC_data", outDataC, 16'h1234);
        outReady = 4'b0100;
        cycle();
        outReady = 4'b0000;
        chk("routeC_empty", outValid, 4'b0000);

        // Stall on A.
        inData = 16'h00AA; inSel = 2'b00; inValid = 1'b1;
        cycle();
        inData = 16'h00BB;
        #1;
        chk("stall_ready", inReady, 0);
        cycle();
        cycle();
        chk("stall_dataA", outDataA, 16'h00AA);
        chk("stall_validA", outValid, 4'b0001);
        outReady = 4'b0001;
        #1;
        chk("unstall_ready", inReady, 1);
        cycle();
        inValid = 1'b0;
        outReady = 4'b0000;
        #1;
        chk("reload_dataA", outDataA, 16'h00BB);
        chk("reload_validA", outValid, 4'b0001);
        outReady = 4'b0001;
        cycle();
        outReady = 4'b0000;

        // Pipe-through on B.
        inData = 16'h00F0; inSel = 2'b01; inValid = 1'b1;
        cycle();
        outReady = 4'b0010;
        for (int k = 1; k <= 8; k++) begin
            inData = W'(k);
            #1;
            chk($sformatf("pipe_ready%0d", k), inReady, 1);
            cycle();
            chk($sformatf("pipe_dataB%0d", k), outDataB, k);
            chk($sformatf("pipe_validB%0d", k), outValid, 4'b0010);
        end
        inValid = 1'b0;
        cycle();
        outReady = 4'b0000;
        chk("pipe_empty", outValid, 4'b0000);
        chkCnt("pipe");

        // Independence: D full and stalled, then A, B, C.
        inData = 16'hDDDD; inSel = 2'b11; inValid = 1'b1;
        cycle();
        for (int s = 0; s < 3; s++) begin
            inSel = 2'(s);
            inData = 16'h0A0A + 16'(s);
            #1;
            chk($sformatf("indep_ready%0d", s), inReady, 1);
            cycle();
        end
        inValid = 1'b0;
        #1;
        chk("indep_valid", outValid, 4'b1111);
        chk("indep_dataD", outDataD, 16'hDDDD);
        chk("indep_dataA", outDataA, 16'h0A0A);
        chk("indep_dataB", outDataB, 16'h0A0B);
        chk("indep_dataC", outDataC, 16'h0A0C);
        inSel = 2'b11;
        #1;
        chk("indep_readyD", inReady, 0);

        // Reset mid-operation discards everything.
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid", outValid, 4'b0000);
        chk("midrst_ready", inReady, 0);
        chk("midrst_dataD", outDataD, 0);
        clearModel();
        chkCnt("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        #1;

`ifdef DEMUX1_4_REG_CNT_EN
        // Counter wrap on C.
        outReady = 4'b0100;
        inSel = 2'b10;
        inValid = 1'b1;
        for (int k = 0; k < 256; k++) begin
            inData = W'(k);
            cycle();
            chk($sformatf("wrap_cntC%0d", k), cntC, expCnt[2]);
        end
        chk("wrap_cnt255", cntC, 8'd255);
        inValid = 1'b0;
        cycle();
        chk("wrap_cnt0", cntC, 8'd0);
        chkCnt("wrap");
        outReady = 4'b0000;
`endif

        for (int i = 0; i < 4; i++)
            chk($sformatf("leftover%0d", i), sbQ[i].size(), 0);
        chk("final_valid", outValid, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
